// File: rtl/frost32_mem_ctrl_pkg.sv
// Shared types for the Frost32 data-port memory controller: CPU access
// encodings, controller FSM states and wait-counter width.
package PkgFrost32MemCtrl;

  typedef enum logic {
    DiatRead  = 1'b0,
    DiatWrite = 1'b1
  } DataInoutAccessType;

  typedef enum logic [1:0] {
    Dias32  = 2'd0,
    Dias16  = 2'd1,
    Dias8   = 2'd2,
    DiasBad = 2'd3
  } DataInoutAccessSize;

  typedef enum logic [1:0] {
    McIdle,
    McAccess,
    McResp
  } MemCtrlState;

  localparam int MSB_POS__MEM_CTRL_WAIT_CNT = 3;

endpackage

// File: rtl/frost32_mem_ctrl_if.sv
// CPU data-port and SRAM-side bus of the memory controller.
// master = CPU plus memory model, slave = controller.
interface frost32_mem_ctrl_if;
  logic        cpu_req;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_access_type;
  logic [1:0]  cpu_access_size;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_error;
  logic        mem_en;
  logic        mem_we;
  logic [29:0] mem_addr;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_access_type, cpu_access_size, mem_rdata,
    input  cpu_rdata, cpu_ready, cpu_error, mem_en, mem_we, mem_addr, mem_byte_en, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_access_type, cpu_access_size, mem_rdata,
    output cpu_rdata, cpu_ready, cpu_error, mem_en, mem_we, mem_addr, mem_byte_en, mem_wdata
  );
endinterface

// File: rtl/frost32_mem_lane_steer.sv
// Little-endian byte-lane steering: byte enables and replicated store data
// for writes, lane extraction with zero-extension for reads.
module frost32_mem_lane_steer
  import PkgFrost32MemCtrl::*;
(
  input  DataInoutAccessSize size,
  input  logic [1:0]         offset,
  input  logic [31:0]        wdata,
  input  logic [31:0]        rdata,
  output logic [3:0]         byte_en,
  output logic [31:0]        wdata_steered,
  output logic [31:0]        rdata_extracted
);
  logic [31:0] rdata_shifted;

  always_comb begin
    byte_en         = 4'b0000;
    wdata_steered   = wdata;
    rdata_extracted = rdata;
    rdata_shifted   = rdata >> {offset, 3'b000};
    case (size)
      Dias32: byte_en = 4'b1111;
      Dias16: begin
        // offset[0] is ignored, so misaligned halfwords snap to alignment
        byte_en         = offset[1] ? 4'b1100 : 4'b0011;
        wdata_steered   = {2{wdata[15:0]}};
        rdata_extracted = {16'h0000, offset[1] ? rdata[31:16] : rdata[15:0]};
      end
      Dias8: begin
        byte_en         = 4'b0001 << offset;
        wdata_steered   = {4{wdata[7:0]}};
        rdata_extracted = {24'h000000, rdata_shifted[7:0]};
      end
      default: byte_en = 4'b0000;
    endcase
  end
endmodule

// File: rtl/frost32_mem_ctrl.sv
// Frost32 data-port memory controller: one access at a time, WAIT_STATES
// stall cycles, lane steering. FROST32_MEM_CTRL_ALIGN_CHECK_EN turns misaligned
// accesses and DiasBad into error responses.
module frost32_mem_ctrl
  import PkgFrost32MemCtrl::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  frost32_mem_ctrl_if.slave  bus
);
  localparam logic [MSB_POS__MEM_CTRL_WAIT_CNT:0] WAIT_INIT =
    WAIT_STATES[MSB_POS__MEM_CTRL_WAIT_CNT:0];
`ifdef FROST32_MEM_CTRL_ALIGN_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  MemCtrlState                      state, state_nxt;
  logic [MSB_POS__MEM_CTRL_WAIT_CNT:0] wait_cnt;
  DataInoutAccessSize               size_q, req_size, st_size;
  logic [1:0]                       off_q, st_off;
  logic                             write_q;
  logic                             req_err;
  logic [3:0]                       st_byte_en;
  logic [31:0]                      st_wdata, st_rdata;

  assign req_size = DataInoutAccessSize'(bus.cpu_access_size);

  // One steering instance: fed from the live request in IDLE (write path)
  // and from the latched request during ACCESS (read path).
  assign st_size = (state == McIdle) ? req_size : size_q;
  assign st_off  = (state == McIdle) ? bus.cpu_addr[1:0] : off_q;

  frost32_mem_lane_steer u_steer (
    .size            (st_size),
    .offset          (st_off),
    .wdata           (bus.cpu_wdata),
    .rdata           (bus.mem_rdata),
    .byte_en         (st_byte_en),
    .wdata_steered   (st_wdata),
    .rdata_extracted (st_rdata)
  );

  always_comb begin
    req_err = (req_size == DiasBad);
`ifdef FROST32_MEM_CTRL_ALIGN_CHECK_EN
    if (req_size == Dias16 && bus.cpu_addr[0])         req_err = 1'b1;
    if (req_size == Dias32 && bus.cpu_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
  end

  always_comb begin
    state_nxt = state;
    case (state)
      McIdle:   if (bus.cpu_req) state_nxt = req_err ? McResp : McAccess;
      McAccess: if (wait_cnt == '0) state_nxt = McResp;
      McResp:   state_nxt = McIdle;
      default:  state_nxt = McIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= McIdle;
      wait_cnt        <= '0;
      size_q          <= Dias32;
      off_q           <= 2'b00;
      write_q         <= 1'b0;
      bus.cpu_rdata   <= '0;
      bus.cpu_ready   <= 1'b0;
      bus.cpu_error   <= 1'b0;
      bus.mem_en      <= 1'b0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_byte_en <= '0;
      bus.mem_wdata   <= '0;
    end else begin
      state         <= state_nxt;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.cpu_ready <= 1'b0;
      bus.cpu_error <= 1'b0;
      case (state)
        McIdle: if (bus.cpu_req) begin
          size_q   <= req_size;
          off_q    <= bus.cpu_addr[1:0];
          write_q  <= bus.cpu_access_type;
          wait_cnt <= WAIT_INIT;
          if (req_err) begin
            bus.cpu_ready <= 1'b1;
            bus.cpu_error <= ERR_EN;
          end else begin
            bus.mem_en      <= 1'b1;
            bus.mem_we      <= bus.cpu_access_type;
            bus.mem_addr    <= bus.cpu_addr[31:2];
            bus.mem_byte_en <= st_byte_en;
            bus.mem_wdata   <= st_wdata;
          end
        end
        McAccess: begin
          if (wait_cnt == '0) begin
            bus.cpu_ready <= 1'b1;
            if (!write_q) bus.cpu_rdata <= st_rdata;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_frost32_mem_ctrl.sv
// Directed bench for frost32_mem_ctrl: one instance with WAIT_STATES=1 for
// lane/error/reset cases, one with WAIT_STATES=0 for back-to-back streaming.
module tb_frost32_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nerr = 0;
  int   nchk = 0;
  int   cyc;
  int   rc, ec, first_r, last_r;

`ifdef FROST32_MEM_CTRL_ALIGN_CHECK_EN
  localparam logic ALIGN = 1'b1;
`else
  localparam logic ALIGN = 1'b0;
`endif

  always #5 clk = ~clk;

  frost32_mem_ctrl_if b1();
  frost32_mem_ctrl_if b0();

  frost32_mem_ctrl #(.WAIT_STATES(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  frost32_mem_ctrl #(.WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] wd, input logic t,
                       input logic [1:0] sz);
    b1.cpu_req = 1'b1;
    b1.cpu_addr = a;
    b1.cpu_wdata = wd;
    b1.cpu_access_type = t;
    b1.cpu_access_size = sz;
    step();
    b1.cpu_req = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (b1.cpu_ready !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    b1.cpu_req = 0; b1.cpu_addr = 0; b1.cpu_wdata = 0;
    b1.cpu_access_type = 0; b1.cpu_access_size = 0; b1.mem_rdata = 0;
    b0.cpu_req = 0; b0.cpu_addr = 0; b0.cpu_wdata = 0;
    b0.cpu_access_type = 0; b0.cpu_access_size = 0; b0.mem_rdata = 0;

    step(); step();
    chk("rst_rdata",   b1.cpu_rdata, 32'h0);
    chk("rst_ready",   {31'h0, b1.cpu_ready}, 32'h0);
    chk("rst_error",   {31'h0, b1.cpu_error}, 32'h0);
    chk("rst_mem_en",  {31'h0, b1.mem_en}, 32'h0);
    chk("rst_byte_en", {28'h0, b1.mem_byte_en}, 32'h0);
    #2 rst_n = 1'b1;
    step();

    // Read Dias32 at 0x100
    b1.mem_rdata = 32'hDEADBEEF;
    issue(32'h100, 32'h0, 1'b0, 2'd0);
    chk("rd32_mem_en",  {31'h0, b1.mem_en}, 32'h1);
    chk("rd32_mem_we",  {31'h0, b1.mem_we}, 32'h0);
    chk("rd32_addr",    {2'b00, b1.mem_addr}, 32'h40);
    chk("rd32_be",      {28'h0, b1.mem_byte_en}, 32'hF);
    step();
    chk("rd32_en_once", {31'h0, b1.mem_en}, 32'h0);
    wait_ready(cyc);
    chk("rd32_latency", cyc, 32'd1);
    chk("rd32_rdata",   b1.cpu_rdata, 32'hDEADBEEF);
    chk("rd32_error",   {31'h0, b1.cpu_error}, 32'h0);
    step();
    chk("rd32_pulse",   {31'h0, b1.cpu_ready}, 32'h0);

    // Sub-word reads
    b1.mem_rdata = 32'hA1B2C3D4;
    issue(32'h103, 32'h0, 1'b0, 2'd2);
    chk("rd8_be", {28'h0, b1.mem_byte_en}, 32'h8);
    wait_ready(cyc);
    chk("rd8_rdata", b1.cpu_rdata, 32'h000000A1);
    step();
    issue(32'h100, 32'h0, 1'b0, 2'd1);
    chk("rd16lo_be", {28'h0, b1.mem_byte_en}, 32'h3);
    wait_ready(cyc);
    chk("rd16lo_rdata", b1.cpu_rdata, 32'h0000C3D4);
    step();
    issue(32'h102, 32'h0, 1'b0, 2'd1);
    chk("rd16_be", {28'h0, b1.mem_byte_en}, 32'hC);
    wait_ready(cyc);
    chk("rd16_rdata", b1.cpu_rdata, 32'h0000A1B2);
    step();

    // Write Dias8 at 0x201
    issue(32'h201, 32'h00000055, 1'b1, 2'd2);
    chk("wr8_mem_en", {31'h0, b1.mem_en}, 32'h1);
    chk("wr8_mem_we", {31'h0, b1.mem_we}, 32'h1);
    chk("wr8_addr",   {2'b00, b1.mem_addr}, 32'h80);
    chk("wr8_be",     {28'h0, b1.mem_byte_en}, 32'h2);
    chk("wr8_wdata",  b1.mem_wdata, 32'h55555555);
    wait_ready(cyc);
    chk("wr8_latency", cyc, 32'd2);
    chk("wr8_rdata_kept", b1.cpu_rdata, 32'h0000A1B2);
    step();

    // Misaligned Dias32 at 0x102
    issue(32'h102, 32'h0, 1'b0, 2'd0);
    if (ALIGN) begin
      chk("mis_mem_en", {31'h0, b1.mem_en}, 32'h0);
      chk("mis_ready",  {31'h0, b1.cpu_ready}, 32'h1);
      chk("mis_error",  {31'h0, b1.cpu_error}, 32'h1);
      chk("mis_rdata_kept", b1.cpu_rdata, 32'h0000A1B2);
    end else begin
      chk("mis_mem_en", {31'h0, b1.mem_en}, 32'h1);
      chk("mis_addr",   {2'b00, b1.mem_addr}, 32'h40);
      chk("mis_be",     {28'h0, b1.mem_byte_en}, 32'hF);
      wait_ready(cyc);
      chk("mis_latency", cyc, 32'd2);
      chk("mis_error",   {31'h0, b1.cpu_error}, 32'h0);
      chk("mis_rdata",   b1.cpu_rdata, 32'hA1B2C3D4);
    end
    step();
    step();

    // DiasBad: no strobe, immediate response
    b1.mem_rdata = 32'h13579BDF;
    issue(32'h100, 32'h0, 1'b0, 2'd3);
    chk("bad_mem_en", {31'h0, b1.mem_en}, 32'h0);
    chk("bad_ready",  {31'h0, b1.cpu_ready}, 32'h1);
    chk("bad_error",  {31'h0, b1.cpu_error}, {31'h0, ALIGN});
    step();
    chk("bad_pulse",  {31'h0, b1.cpu_ready}, 32'h0);
    chk("bad_rdata_kept", b1.cpu_rdata, ALIGN ? 32'h0000A1B2 : 32'hA1B2C3D4);

    // Reset during a write access
    issue(32'h300, 32'h12345678, 1'b1, 2'd0);
    chk("rstw_mem_en", {31'h0, b1.mem_en}, 32'h1);
    chk("rstw_wdata",  b1.mem_wdata, 32'h12345678);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_async_en",    {31'h0, b1.mem_en}, 32'h0);
    chk("rstw_async_we",    {31'h0, b1.mem_we}, 32'h0);
    chk("rstw_async_addr",  {2'b00, b1.mem_addr}, 32'h0);
    chk("rstw_async_wdata", b1.mem_wdata, 32'h0);
    chk("rstw_async_rdata", b1.cpu_rdata, 32'h0);
    rc = 0;
    repeat (3) begin
      step();
      if (b1.cpu_ready) rc++;
    end
    #2 rst_n = 1'b1;
    repeat (3) begin
      step();
      if (b1.cpu_ready) rc++;
    end
    chk("rstw_no_ack", rc, 32'd0);
    b1.mem_rdata = 32'hDEADBEEF;
    issue(32'h100, 32'h0, 1'b0, 2'd0);
    chk("post_rst_en", {31'h0, b1.mem_en}, 32'h1);
    wait_ready(cyc);
    chk("post_rst_latency", cyc, 32'd2);
    chk("post_rst_rdata", b1.cpu_rdata, 32'hDEADBEEF);
    step();

    // Back-to-back with WAIT_STATES=0, request held high
    b0.mem_rdata = 32'h0BADF00D;
    b0.cpu_addr = 32'h10;
    b0.cpu_access_type = 1'b0;
    b0.cpu_access_size = 2'd0;
    b0.cpu_req = 1'b1;
    rc = 0; ec = 0; first_r = -1; last_r = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (b0.mem_en) ec++;
      if (b0.cpu_ready) begin
        rc++;
        if (first_r < 0) first_r = i;
        last_r = i;
      end
    end
    b0.cpu_req = 1'b0;
    chk("b2b_ready_cnt", rc, 32'd4);
    chk("b2b_en_cnt",    ec, 32'd4);
    chk("b2b_first",     first_r, 32'd1);
    chk("b2b_period",    last_r - first_r, 32'd9);
    chk("b2b_rdata",     b0.cpu_rdata, 32'h0BADF00D);
    step(); step();
    chk("b2b_idle_en",   {31'h0, b0.mem_en}, 32'h0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
